// File: rtl/spi_flash_read_seq.sv
// Wishbone master that sequences the 8-bit SPI master register block through a
// serial-flash READ (0x03 + 24-bit address + N bytes) and streams the data out.
module spi_flash_read_seq #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CS_MASK    = 8'h01,
  parameter logic [7:0]  SPCR_VAL   = 8'h40,
  parameter logic [7:0]  SPER_VAL   = 8'h00,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [23:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [7:0]       rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [2:0]       wbm_adr_o,
  output logic [7:0]       wbm_dat_o,
  input  logic [7:0]       wbm_dat_i,
  input  logic             wbm_ack_i
);
  localparam int unsigned TW = LEN_W + 1;
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_CTRL, S_CFG_EXT, S_CS_ON, S_SCHED,
    S_PUSH, S_POLL, S_POP, S_CS_OFF, S_FIN
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tx_left, r_rx_left;
  logic [OW-1:0]   r_outst;
  logic [2:0]      r_hdr_skip;
  logic [31:0]     r_hdr;
  logic [WW-1:0]   r_wdog;
  logic            r_cyc, r_we, r_done, r_err, r_rd_valid;
  logic [2:0]      r_adr;
  logic [7:0]      r_dat, r_rd_data;

  logic            w_acc, w_we;
  logic [2:0]      w_adr;
  logic [7:0]      w_dat;

  // Bus access each state issues once the previous cycle has dropped.
  always_comb begin
    w_acc = 1'b1;
    w_we  = 1'b1;
    w_adr = '0;
    w_dat = '0;
    case (r_state)
      S_CFG_CTRL: begin w_adr = 3'd0; w_dat = SPCR_VAL; end
      S_CFG_EXT:  begin w_adr = 3'd3; w_dat = SPER_VAL; end
      S_CS_ON:    begin w_adr = 3'd4; w_dat = CS_MASK; end
      S_PUSH:     begin w_adr = 3'd2; w_dat = r_hdr[31:24]; end
      S_POLL:     begin w_adr = 3'd1; w_we = 1'b0; end
      S_POP:      begin w_adr = 3'd2; w_we = 1'b0; end
      S_CS_OFF:   begin w_adr = 3'd4; w_dat = '0; end
      default:    w_acc = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_tx_left  <= '0;
      r_rx_left  <= '0;
      r_outst    <= '0;
      r_hdr_skip <= '0;
      r_hdr      <= '0;
      r_wdog     <= '0;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_rd_valid && rd_ready_i) r_rd_valid <= 1'b0;
      if (r_cyc) begin
        if (wbm_ack_i) begin
          r_cyc  <= 1'b0;
          r_we   <= 1'b0;
          r_adr  <= '0;
          r_dat  <= '0;
          r_wdog <= '0;
          case (r_state)
            S_CFG_CTRL: r_state <= S_CFG_EXT;
            S_CFG_EXT:  r_state <= S_CS_ON;
            S_CS_ON:    r_state <= S_SCHED;
            S_PUSH: begin
              r_tx_left <= r_tx_left - TW'(1);
              r_outst   <= r_outst + OW'(1);
              r_hdr     <= {r_hdr[23:0], 8'h00};
              r_state   <= S_SCHED;
            end
            S_POLL: r_state <= wbm_dat_i[0] ? S_SCHED : S_POP;
            S_POP: begin
              r_outst   <= r_outst - OW'(1);
              r_rx_left <= r_rx_left - TW'(1);
              if (r_hdr_skip != '0) begin
                r_hdr_skip <= r_hdr_skip - 3'd1;
              end else begin
                r_rd_data  <= wbm_dat_i;
                r_rd_valid <= 1'b1;
              end
              r_state <= S_SCHED;
            end
            S_CS_OFF: r_state <= S_FIN;
            default:  r_state <= S_IDLE;
          endcase
        end else if (r_wdog == WW'(TIMEOUT - 1)) begin
          // Abort leaves CS asserted; recovery of the slave is left to software.
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
          r_adr   <= '0;
          r_dat   <= '0;
          r_wdog  <= '0;
          r_done  <= 1'b1;
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_wdog <= r_wdog + WW'(1);
        end
      end else begin
        r_wdog <= '0;
        if (w_acc) begin
          r_cyc <= 1'b1;
          r_we  <= w_we;
          r_adr <= w_adr;
          r_dat <= w_dat;
        end
        case (r_state)
          S_IDLE: if (req_valid_i) begin
            r_tx_left  <= TW'(req_len_i) + TW'(4);
            r_rx_left  <= TW'(req_len_i) + TW'(4);
            r_hdr_skip <= 3'd4;
            r_outst    <= '0;
            r_hdr      <= {8'h03, req_addr_i};
            r_state    <= S_CFG_CTRL;
          end
          S_SCHED: begin
            if (r_rx_left == '0)
              r_state <= S_CS_OFF;
            else if (r_tx_left != '0 && r_outst < OW'(FIFO_DEPTH))
              r_state <= S_PUSH;
            else if (r_outst != '0 && (r_hdr_skip != '0 || !r_rd_valid))
              r_state <= S_POLL;
          end
          S_FIN: if (!r_rd_valid) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rd_valid_o  = r_rd_valid;
  assign rd_data_o   = r_rd_data;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: behavioural SPI-master register block with a
// serial-flash responder, plus scoreboards for bus writes and the read stream.
module tb_spi_flash_read_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rd_valid, rd_ready, busy, done, err;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic [7:0]  rd_data;
  logic        cyc, stb, we, ack;
  logic [2:0]  adr;
  logic [7:0]  dat_o, dat_i;

  always #5 clk = ~clk;

  spi_flash_read_seq #(.LEN_W(16), .FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fb(input logic [23:0] a);
    if (a == 24'h123456) return 8'hA5;
    if (a == 24'h123457) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  logic [10:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  rxq_d[$];
  int          rxq_t[$];
  int          cyc_cnt = 0, last_done = 0, out_cnt = 0, max_out = 0, wr_idx = 0;
  int          pops = 0, done_cnt = 0, run = 0, last_run = 0;
  bit          noack = 0, rdv_seen = 0, last_err, last_cyc, last_rdy;
  logic [23:0] fl_addr = '0;

  // SPI register block + flash model, and output monitors.
  always @(negedge clk) begin
    int t;
    logic [7:0] resp;
    cyc_cnt++;
    if (!rst_n) begin
      ack = 1'b0; dat_i = 8'h00;
      rxq_d.delete(); rxq_t.delete();
      out_cnt = 0; wr_idx = 0; last_done = 0; run = 0;
    end else begin
      if (cyc) run++;
      else if (run != 0) begin last_run = run; run = 0; end
      if (rd_valid) rdv_seen = 1;
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_extra", {24'h0, rd_data}, 32'h1FF);
        else chk("rd_data", {24'h0, rd_data}, {24'h0, exp_rd.pop_front()});
      end
      if (done) begin
        done_cnt++; last_err = err; last_cyc = cyc; last_rdy = req_ready;
      end
      if (cyc && !ack && !noack) begin
        ack = 1'b1; dat_i = 8'h00;
        chk("stb_eq_cyc", stb, 1);
        if (we) begin
          if (exp_wr.size() == 0) chk("wb_wr_extra", {21'h0, adr, dat_o}, 32'hFFFF_FFFF);
          else chk("wb_wr", {21'h0, adr, dat_o}, {21'h0, exp_wr.pop_front()});
          if (adr == 3'd4 && dat_o != 8'h00) wr_idx = 0;
          if (adr == 3'd2) begin
            chk("spi_no_wcol", out_cnt < 4, 1);
            out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
            case (wr_idx)
              1: fl_addr[23:16] = dat_o;
              2: fl_addr[15:8]  = dat_o;
              3: fl_addr[7:0]   = dat_o;
              default: ;
            endcase
            resp = (wr_idx < 4) ? 8'hFF : fb(fl_addr + 24'(wr_idx - 4));
            t = ((cyc_cnt > last_done) ? cyc_cnt : last_done) + 8;
            last_done = t;
            rxq_d.push_back(resp); rxq_t.push_back(t);
            wr_idx++;
          end
        end else if (adr == 3'd1) begin
          dat_i = {7'h0, !(rxq_t.size() != 0 && rxq_t[0] <= cyc_cnt)};
        end else if (adr == 3'd2) begin
          pops++;
          if (rxq_d.size() == 0) chk("spi_rd_underrun", rxq_d.size(), 1);
          else begin
            dat_i = rxq_d.pop_front();
            void'(rxq_t.pop_front());
            out_cnt--;
          end
        end
      end else begin
        ack = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [23:0] a, input int unsigned n, input bit track);
    if (track) begin
      exp_wr.push_back({3'd0, 8'h40});
      exp_wr.push_back({3'd3, 8'h00});
      exp_wr.push_back({3'd4, 8'h01});
      exp_wr.push_back({3'd2, 8'h03});
      exp_wr.push_back({3'd2, a[23:16]});
      exp_wr.push_back({3'd2, a[15:8]});
      exp_wr.push_back({3'd2, a[7:0]});
      for (int i = 0; i < int'(n); i++) begin
        exp_wr.push_back({3'd2, 8'h00});
        exp_rd.push_back(fb(a + 24'(i)));
      end
      exp_wr.push_back({3'd4, 8'h00});
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = 16'(n);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxc && done_cnt == d0; i++) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rd_ready = 1'b1;
    #3;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_done", {done, err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic read, two data bytes
    do_req(24'h123456, 2, 1);
    wait_done(1000);
    chk("t1_err", last_err, 0);
    chk("t1_rdy", last_rdy, 1);
    repeat (5) @(negedge clk);
    chk("t1_single_done", done_cnt, 1);
    chk("t1_rd_left", exp_rd.size(), 0);
    chk("t1_wr_left", exp_wr.size(), 0);

    // Header only
    pops = 0; rdv_seen = 0;
    do_req(24'h00ABCD, 0, 1);
    wait_done(1000);
    chk("t2_pops", pops, 4);
    chk("t2_no_rdv", rdv_seen, 0);
    chk("t2_wr_left", exp_wr.size(), 0);

    // Back-pressure: consumer stalled
    max_out = 0; rd_ready = 1'b0;
    do_req(24'h00FFF8, 16, 1);
    repeat (600) @(negedge clk);
    chk("t3_stalled_busy", busy, 1);
    chk("t3_stalled_rdv", rd_valid, 1);
    chk("t3_stalled_data", rd_data, fb(24'h00FFF8));
    chk("t3_max_outst", max_out, 4);
    rd_ready = 1'b1;
    wait_done(3000);
    chk("t3_err", last_err, 0);
    chk("t3_rd_left", exp_rd.size(), 0);

    // Slave never acknowledges
    noack = 1;
    do_req(24'h000100, 1, 0);
    wait_done(600);
    chk("t4_err", last_err, 1);
    chk("t4_cyc_len", last_run, 255);
    chk("t4_cyc_low", last_cyc, 0);
    chk("t4_ready", last_rdy, 1);
    noack = 0;

    // Asynchronous reset during a data-register push
    do_req(24'h111111, 3, 1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc && adr == 3'd2 && we) break;
    end
    chk("t5_in_push", {cyc, adr}, {1'b1, 3'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cyc", {cyc, stb}, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 1);
    exp_wr.delete(); exp_rd.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(24'h222222, 2, 1);
    wait_done(1000);
    chk("t5_err", last_err, 0);
    chk("t5_rd_left", exp_rd.size(), 0);

    // Request while busy is ignored
    do_req(24'h333333, 3, 1);
    repeat (10) @(posedge clk);
    #1 req_valid = 1'b1; req_addr = 24'h444444; req_len = 16'd5;
    @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_not_ready", req_ready, 0);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_done(1000);
    repeat (20) @(negedge clk);
    chk("t6_idle_after", busy, 0);
    do_req(24'h444444, 1, 1);
    wait_done(1000);
    chk("t6_rd_left", exp_rd.size(), 0);
    chk("t6_wr_left", exp_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
